// File: rtl/intersection_phase_sequencer.sv
// ---------------------------------------------------------------------------
// intersection_phase_sequencer
//
// Purpose:
//   Phase state machine and arbiter for a two-road intersection (north-south
//   and east-west) sharing one crossing. Green is granted to one road at a
//   time. Each green is followed by yellow and then all-red clearance.
//   Service alternates between the roads and is driven by latched sensor
//   calls. All lamp outputs are decoded directly from the state register.
//
// Optional feature (build macro PED_WALK_EN):
//   Adds a pedestrian push-button input and a walk lamp output. A latched
//   pedestrian call counts as an opposing call for ending a green. It inserts
//   a PED_WALK phase after the all-red clearance. That phase goes straight on
//   to the pending green without a second all-red.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   ns_req     in   north-south vehicle sensor (level)
//   ew_req     in   east-west vehicle sensor (level)
//   ped_req    in   pedestrian push-button (level)      [PED_WALK_EN only]
//   walk       out  pedestrian walk lamp                [PED_WALK_EN only]
//   ns_red/ns_yellow/ns_green   out  north-south lamps
//   ew_red/ew_yellow/ew_green   out  east-west lamps
//   phase      out  [2:0] current state code
//                   0=ALL_RED 1=NS_GREEN 2=NS_YELLOW 3=EW_GREEN 4=EW_YELLOW
//                   5=PED_WALK
// ---------------------------------------------------------------------------
module intersection_phase_sequencer #(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 10,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    parameter int WALK_TIME   = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ns_req,
    input  logic       ew_req,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic [2:0] phase
);

    // Parameter range checks at elaboration time.
    if (MIN_GREEN < 1 || MIN_GREEN > 255) begin : g_bad_min_green
        $error("MIN_GREEN out of range 1..255");
    end
    if (MAX_GREEN < MIN_GREEN || MAX_GREEN > 255) begin : g_bad_max_green
        $error("MAX_GREEN out of range MIN_GREEN..255");
    end
    if (YELLOW_TIME < 1 || YELLOW_TIME > 255) begin : g_bad_yellow
        $error("YELLOW_TIME out of range 1..255");
    end
    if (ALLRED_TIME < 1 || ALLRED_TIME > 255) begin : g_bad_allred
        $error("ALLRED_TIME out of range 1..255");
    end
    if (WALK_TIME < 1 || WALK_TIME > 255) begin : g_bad_walk
        $error("WALK_TIME out of range 1..255");
    end

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4
`ifdef PED_WALK_EN
        ,
        PED_WALK  = 3'd5
`endif
    } state_e;

    // A state of duration T leaves on the edge where the timer reads T-1.
    localparam logic [7:0] MIN_LAST    = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MAX_LAST    = 8'(MAX_GREEN - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TIME - 1);
`ifdef PED_WALK_EN
    localparam logic [7:0] WALK_LAST   = 8'(WALK_TIME - 1);
`endif

    state_e     state_q,   state_d;
    logic [7:0] timer_q,   timer_d;
    logic       ns_call_q, ns_call_d;
    logic       ew_call_q, ew_call_d;
    // 1 when east-west was the road served most recently, 0 for north-south.
    logic       last_ew_q, last_ew_d;
    logic       ped_call;

`ifdef PED_WALK_EN
    logic       ped_call_q, ped_call_d;
    assign ped_call = ped_call_q;
`else
    assign ped_call = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ALL_RED;
            timer_q   <= 8'd0;
            ns_call_q <= 1'b0;
            ew_call_q <= 1'b0;
            last_ew_q <= 1'b1;   // makes north-south the first road served
`ifdef PED_WALK_EN
            ped_call_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ns_call_q <= ns_call_d;
            ew_call_q <= ew_call_d;
            last_ew_q <= last_ew_d;
`ifdef PED_WALK_EN
            ped_call_q <= ped_call_d;
`endif
        end
    end

    // Next state, timer, calls and lamp decode.
    always_comb begin
        state_d   = state_q;
        last_ew_d = last_ew_q;
        timer_d   = timer_q;
        ns_call_d = ns_call_q;
        ew_call_d = ew_call_q;
`ifdef PED_WALK_EN
        ped_call_d = ped_call_q;
        walk       = 1'b0;
`endif
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        phase     = state_q;

        case (state_q)
            ALL_RED: begin
                if (timer_q >= ALLRED_LAST) begin
`ifdef PED_WALK_EN
                    if (ped_call) begin
                        state_d = PED_WALK;
                    end else
`endif
                    begin
                        // Entered unconditionally: serve the other road.
                        state_d = last_ew_q ? NS_GREEN : EW_GREEN;
                    end
                end
            end
            NS_GREEN: begin
                ns_red   = 1'b0;
                ns_green = 1'b1;
                // The MAX_GREEN force-off only matters while the own sensor is
                // still occupied. An empty road yields as soon as MIN_GREEN is met.
                if (timer_q >= MIN_LAST && (ew_call_q || ped_call) &&
                    (!ns_req || timer_q >= MAX_LAST)) begin
                    state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                ns_red    = 1'b0;
                ns_yellow = 1'b1;
                if (timer_q >= YELLOW_LAST) begin
                    state_d   = ALL_RED;
                    last_ew_d = 1'b0;
                end
            end
            EW_GREEN: begin
                ew_red   = 1'b0;
                ew_green = 1'b1;
                if (timer_q >= MIN_LAST && (ns_call_q || ped_call) &&
                    (!ew_req || timer_q >= MAX_LAST)) begin
                    state_d = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                ew_red    = 1'b0;
                ew_yellow = 1'b1;
                if (timer_q >= YELLOW_LAST) begin
                    state_d   = ALL_RED;
                    last_ew_d = 1'b1;
                end
            end
`ifdef PED_WALK_EN
            PED_WALK: begin
                walk = 1'b1;
                if (timer_q >= WALK_LAST) begin
                    state_d = last_ew_q ? NS_GREEN : EW_GREEN;
                end
            end
`endif
            default: begin
                // Unused codes recover to all-red on the next edge.
                state_d = ALL_RED;
            end
        endcase

        // The timer restarts on every state change and saturates at 255.
        // It therefore never wraps, and a long rest still meets all thresholds.
        if (state_d != state_q) begin
            timer_d = 8'd0;
        end else if (timer_q != 8'hFF) begin
            timer_d = timer_q + 8'd1;
        end

        // Calls latch while the road is not green. Clearing on green entry
        // takes priority over a set in the same cycle.
        if (ns_req && state_q != NS_GREEN) begin
            ns_call_d = 1'b1;
        end
        if (state_d == NS_GREEN && state_q != NS_GREEN) begin
            ns_call_d = 1'b0;
        end
        if (ew_req && state_q != EW_GREEN) begin
            ew_call_d = 1'b1;
        end
        if (state_d == EW_GREEN && state_q != EW_GREEN) begin
            ew_call_d = 1'b0;
        end
`ifdef PED_WALK_EN
        if (ped_req) begin
            ped_call_d = 1'b1;
        end
        if (state_d == PED_WALK && state_q != PED_WALK) begin
            ped_call_d = 1'b0;
        end
`endif
    end

endmodule

// File: doc/intersection_phase_sequencer.md
Name: intersection_phase_sequencer

Overview:
- Sequences a two-road intersection (north-south, east-west) that shares one crossing. Each road's red/yellow/green lamps are driven from a single phase state machine.
- Acts as the arbiter for the crossing. It grants green to one road at a time, inserts yellow and all-red clearance between grants, and alternates service between roads based on latched vehicle-sensor calls.
- Sits above the per-road lamp drivers and is the only source of lamp outputs in the intersection top level.

Parameters:
- MIN_GREEN, 4: minimum green duration in cycles; range 1..255.
- MAX_GREEN, 10: green duration after which a road is forced off when the opposing road has a call; range MIN_GREEN..255.
- YELLOW_TIME, 2: yellow duration in cycles; range 1..255.
- ALLRED_TIME, 1: all-red clearance duration in cycles; range 1..255.
- WALK_TIME, 6: pedestrian walk duration in cycles (PED_WALK_EN only); range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ns_req  input  1  north-south vehicle sensor, level, synchronous to clk.
- ew_req  input  1  east-west vehicle sensor, level, synchronous to clk.
- ns_red, ns_yellow, ns_green  output  1 each  north-south lamps.
- ew_red, ew_yellow, ew_green  output  1 each  east-west lamps.
- phase  output  3  current state encoding, for debug and status.
- ped_req  input  1  pedestrian push-button, level (PED_WALK_EN only).
- walk  output  1  pedestrian walk lamp (PED_WALK_EN only).

Behaviour:
- One clock domain, clk. reset_n is asynchronous, active-low.
- States and phase encoding: ALL_RED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, PED_WALK=5. Codes 6–7 are illegal and return to ALL_RED on the next edge.
- Reset (reset_n low):
  - state=ALL_RED, timer=0, both calls cleared, last_served=EW, so north-south is served first.
  - ns_red=ew_red=1; all other lamps and walk=0; phase=0.
  - Reset asserted mid-phase takes effect immediately, without waiting for a clock edge.
- Outputs are decoded directly from the state register; there is no extra latency.
  - The served road shows green or yellow; the other road shows red.
  - In ALL_RED and PED_WALK both roads show red.
  - Exactly one lamp per road is lit at all times.
- Timer:
  - 8 bits, cleared on every state change, otherwise increments.
  - Saturates at 255; it never wraps.
  - A state of duration T exits on the edge where timer==T-1, so it is held exactly T cycles.
- Calls:
  - ns_call is set when ns_req=1 while not in NS_GREEN, and cleared on entry to NS_GREEN. ew_call follows the same rule for EW.
  - Set and clear in the same cycle: clear wins.
- Green of road X (opposing road Y):
  - No exit before the timer reaches MIN_GREEN-1.
  - After that, exit to X_YELLOW when Y's call is set AND either X's sensor is low or the timer has reached MAX_GREEN-1.
  - With no opposing call, green rests indefinitely.
- X_YELLOW lasts YELLOW_TIME cycles, then goes to ALL_RED. last_served=X.
- ALL_RED lasts ALLRED_TIME cycles, then goes to the green of the road that is not last_served. This transition happens regardless of calls.
- Both sensors high continuously: roads alternate, each holding green for MAX_GREEN cycles.

Optional Feature:
- Macro: PED_WALK_EN.
- When defined:
  - The ped_req and walk ports exist.
  - ped_call is set by ped_req and cleared on entry to PED_WALK.
  - ped_call counts as an opposing call for the green-exit rule.
  - On ALL_RED exit with ped_call set, the block enters PED_WALK: walk=1, both roads red, for WALK_TIME cycles. It then goes directly to the pending green without a second all-red.
- When undefined: the ped_req and walk ports, ped_call and PED_WALK are absent, and phase value 5 is illegal.

Test Plan:
- Release reset with no requests: ALL_RED lasts 1 cycle; ns_green rises on the 1st edge after release and stays high for 50+ cycles; ew_red stays 1.
- In NS_GREEN, pulse ew_req for 1 cycle at timer=1 with ns_req low: NS green lasts 4 cycles total, yellow 2, all-red 1, then ew_green=1 and ew_call reads cleared.
- Hold ns_req high and assert ew_req at timer=0: NS green lasts exactly 10 cycles, then NS_YELLOW (phase=2).
- Hold both sensors high for 60 cycles: phase sequence 1,2,0,3,4,0 repeats with period 26 cycles; never more than one road non-red.
- Drive reset_n low mid-NS_YELLOW: all lamps go red immediately and asynchronously, phase=0; after release, north-south is served first.
- (PED_WALK_EN) During NS green, pulse ped_req at timer=5 with ns_req low: yellow 2, all-red 1, walk=1 for 6 cycles, then ew_green.
